// File: rtl/rucksack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rucksack_pkg
// Description : Shared types and constants for the rucksack priority loader:
//               FSM state encoding, ASCII codes and priority byte limits.
// Revision    : 1.0 - initial release
// ============================================================================
package rucksack_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_CLOSE = 3'd2,
      ST_END   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LC_A = 8'h61;
   localparam logic [7:0] ASCII_LC_Z = 8'h7A;
   localparam logic [7:0] ASCII_UC_A = 8'h41;
   localparam logic [7:0] ASCII_UC_Z = 8'h5A;

   localparam logic [7:0] PRIO_TERM  = 8'd0;
   localparam logic [7:0] PRIO_MAX   = 8'd52;

endpackage
`default_nettype wire

// File: rtl/rucksack_ascii_to_prio.sv
`default_nettype none
// ============================================================================
// Module      : rucksack_ascii_to_prio
// Description : Combinational classifier: ASCII byte -> letter / LF / CR flags
//               and the letter's priority ('a'..'z' = 1..26, 'A'..'Z' = 27..52,
//               anything else = PRIO_TERM).
// Revision    : 1.0 - initial release
// ============================================================================
module rucksack_ascii_to_prio
   import rucksack_pkg::*;
(
   input  logic [7:0] char_i,
   output logic       is_letter_o,
   output logic       is_lf_o,
   output logic       is_cr_o,
   output logic [7:0] prio_o
);

   logic w_is_lower;
   logic w_is_upper;

   assign w_is_lower  = (char_i >= ASCII_LC_A) && (char_i <= ASCII_LC_Z);
   assign w_is_upper  = (char_i >= ASCII_UC_A) && (char_i <= ASCII_UC_Z);
   assign is_letter_o = w_is_lower | w_is_upper;
   assign is_lf_o     = (char_i == ASCII_LF);
   assign is_cr_o     = (char_i == ASCII_CR);

   // Upper case counts down from the top priority so 'Z' lands exactly on PRIO_MAX.
   always_comb begin
      prio_o = PRIO_TERM;
      if (w_is_lower) begin
         prio_o = char_i - ASCII_LC_A + 8'd1;
      end else if (w_is_upper) begin
         prio_o = PRIO_MAX - (ASCII_UC_Z - char_i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/rucksack_prio_loader.sv
`default_nettype none
// ============================================================================
// Module      : rucksack_prio_loader
// Description : Streams ASCII puzzle text (valid/ready) into the solver memory
//               as priority bytes, 0 after each non-empty line and a second 0
//               as end-of-data marker. Reserves two words for terminators.
//               Optional feature macro: RUCKSACK_CR_SKIP_EN (drop '\r' silently).
// Revision    : 1.0 - initial release
// ============================================================================
module rucksack_prio_loader
   import rucksack_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = (1 << ADDR_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              done,
   output logic [15:0]       line_count,
   output logic              bad_char,
   output logic              overflow
);

   // First address at which letters can no longer be stored.
   localparam logic [ADDR_W-1:0] c_FULL_ADDR = ADDR_W'(DEPTH - 2);
`ifdef RUCKSACK_CR_SKIP_EN
   localparam logic c_CR_SKIP = 1'b1;
`else
   localparam logic c_CR_SKIP = 1'b0;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              line_open_q, line_open_d;
   logic [15:0]       line_count_q, line_count_d;
   logic              bad_char_q, bad_char_d;
   logic              overflow_q, overflow_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              in_ready_q, in_ready_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;

   logic              w_is_letter;
   logic              w_is_lf;
   logic              w_is_cr;
   logic [7:0]        w_prio;
   logic              w_accept;
   logic              w_full;

   rucksack_ascii_to_prio u_a2p (
      .char_i      (in_data),
      .is_letter_o (w_is_letter),
      .is_lf_o     (w_is_lf),
      .is_cr_o     (w_is_cr),
      .prio_o      (w_prio)
   );

   assign w_accept = in_valid & in_ready_q;
   assign w_full   = (addr_q >= c_FULL_ADDR);

   // Next-state, memory write and flag logic for the load FSM.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      line_open_d  = line_open_q;
      line_count_d = line_count_q;
      bad_char_d   = bad_char_q;
      overflow_d   = overflow_q;
      done_d       = done_q;
      busy_d       = busy_q;
      in_ready_d   = 1'b0;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_RUN;
               addr_d       = '0;
               line_open_d  = 1'b0;
               line_count_d = 16'd0;
               bad_char_d   = 1'b0;
               overflow_d   = 1'b0;
               done_d       = 1'b0;
               busy_d       = 1'b1;
               in_ready_d   = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_accept) begin
               if (w_is_letter) begin
                  if (w_full) begin
                     overflow_d = 1'b1;
                     state_d    = line_open_q ? ST_CLOSE : ST_END;
                  end else begin
                     wr_en_d     = 1'b1;
                     wr_addr_d   = addr_q;
                     wr_data_d   = w_prio;
                     addr_d      = addr_q + ADDR_W'(1);
                     line_open_d = 1'b1;
                  end
               end else if (w_is_lf) begin
                  if (line_open_q) begin
                     wr_en_d      = 1'b1;
                     wr_addr_d    = addr_q;
                     wr_data_d    = PRIO_TERM;
                     addr_d       = addr_q + ADDR_W'(1);
                     line_count_d = line_count_q + 16'd1;
                     line_open_d  = 1'b0;
                  end
               end else if (!(w_is_cr && c_CR_SKIP)) begin
                  bad_char_d = 1'b1;
               end
               if (in_last && (state_d == ST_RUN)) begin
                  state_d = line_open_d ? ST_CLOSE : ST_END;
               end
            end else if (in_valid && w_full && w_is_letter) begin
               // Letter waiting with no room left: truncate without consuming it.
               overflow_d = 1'b1;
               state_d    = line_open_q ? ST_CLOSE : ST_END;
            end
            // Near the capacity limit, ready is only raised again for a
            // waiting non-letter, so a letter is never consumed when full.
            if (state_d == ST_RUN) begin
               in_ready_d = (addr_d < c_FULL_ADDR) ||
                            (in_valid && !w_is_letter && !w_accept);
            end
         end
         ST_CLOSE: begin
            wr_en_d      = 1'b1;
            wr_addr_d    = addr_q;
            wr_data_d    = PRIO_TERM;
            addr_d       = addr_q + ADDR_W'(1);
            line_count_d = line_count_q + 16'd1;
            line_open_d  = 1'b0;
            state_d      = ST_END;
         end
         ST_END: begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = PRIO_TERM;
            addr_d    = addr_q + ADDR_W'(1);
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         line_open_q  <= 1'b0;
         line_count_q <= 16'd0;
         bad_char_q   <= 1'b0;
         overflow_q   <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         in_ready_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         line_open_q  <= line_open_d;
         line_count_q <= line_count_d;
         bad_char_q   <= bad_char_d;
         overflow_q   <= overflow_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         in_ready_q   <= in_ready_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign line_count = line_count_q;
   assign bad_char   = bad_char_q;
   assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rucksack_prio_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rucksack_prio_loader
// Description : Scoreboard bench for rucksack_prio_loader (ADDR_W=3, DEPTH=8).
//               Expected memory writes are queued per load; a negedge monitor
//               pops and compares every write the DUT issues.
//               Honours RUCKSACK_CR_SKIP_EN for the CRLF vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rucksack_prio_loader;

   localparam int ADDR_W = 3;

`ifdef RUCKSACK_CR_SKIP_EN
   localparam logic c_CR_BAD = 1'b0;
`else
   localparam logic c_CR_BAD = 1'b1;
`endif

   typedef struct {
      int addr;
      int data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        in_data = 8'd0;
   logic              in_valid = 1'b0;
   logic              in_last = 1'b0;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy;
   logic              done;
   logic [15:0]       line_count;
   logic              bad_char;
   logic              overflow;

   wr_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;
   bit  mon_en   = 1'b1;

   rucksack_prio_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .line_count (line_count),
      .bad_char   (bad_char),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Monitor: every memory write must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n && mon_en && wr_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_unexpected actual=addr%0d/data%0d expected=no write",
                     wr_addr, wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", int'(wr_addr), e.addr);
            chk("wr_data", int'(wr_data), e.data);
         end
      end
   end

   // Queue n expected bytes for addresses 0..n-1, packed MSB-first.
   task automatic push_exp(input int n, input logic [63:0] bytes);
      for (int i = 0; i < n; i++) begin
         wr_t e;
         e.addr = i;
         e.data = int'(bytes[8*(n-1-i) +: 8]);
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Present one byte and hold it until accepted or the budget runs out.
   task automatic drive_byte(input logic [7:0] b, input logic last, input bit gaps,
                             output bit ok);
      ok = 1'b0;
      if (gaps) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      in_last  = last;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_case(input string name, input string s, input int n_exp,
                           input logic [63:0] exp_bytes, input int exp_lines,
                           input logic exp_bad, input logic exp_ovf,
                           input int exp_consumed, input bit gaps);
      int consumed;
      bit ok;
      bit seen;
      push_exp(n_exp, exp_bytes);
      pulse_start();
      consumed = 0;
      for (int i = 0; i < s.len(); i++) begin
         drive_byte(s[i], (i == s.len() - 1), gaps, ok);
         if (!ok) break;
         consumed++;
      end
      chk({name, ".consumed"}, consumed, exp_consumed);
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk({name, ".done"}, int'(seen), 1);
      @(negedge clk);
      chk({name, ".pending_writes"}, exp_q.size(), 0);
      exp_q.delete();
      chk({name, ".line_count"}, int'(line_count), exp_lines);
      chk({name, ".bad_char"}, int'(bad_char), int'(exp_bad));
      chk({name, ".overflow"}, int'(overflow), int'(exp_ovf));
      chk({name, ".busy"}, int'(busy), 0);
      chk({name, ".in_ready"}, int'(in_ready), 0);
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, ".ctl"}, int'({in_ready, wr_en, busy, done, bad_char, overflow}), 0);
      chk({name, ".data"}, int'({wr_addr, wr_data, line_count}), 0);
   endtask

   initial begin
      bit ok;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_case("c1_aB_c", "aB\nc\n", 6, 64'h01_1C_00_03_00_00, 2, 1'b0, 1'b0, 5, 1'b0);
      run_case("c2_z_last", "z", 3, 64'h1A_00_00, 1, 1'b0, 1'b0, 1, 1'b0);
      run_case("c3_blank", "a\n\nb\n", 5, 64'h01_00_02_00_00, 2, 1'b0, 1'b0, 5, 1'b0);
      run_case("c4_bad", "a1b\n", 4, 64'h01_02_00_00, 1, 1'b1, 1'b0, 4, 1'b0);
      run_case("c5_ovf", "abcdefghij", 8, 64'h01_02_03_04_05_06_00_00, 1, 1'b0, 1'b1, 6,
               1'b0);

      // Aborted load: writes are not scored, reset must clear all outputs.
      mon_en = 1'b0;
      pulse_start();
      drive_byte("a", 1'b0, 1'b1, ok);
      drive_byte("B", 1'b0, 1'b1, ok);
      drive_byte("\n", 1'b0, 1'b1, ok);
      in_data  = "c";
      in_valid = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort_rst");
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("abort_hold");
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      mon_en = 1'b1;

      run_case("c6_restart", "aB\nc\n", 6, 64'h01_1C_00_03_00_00, 2, 1'b0, 1'b0, 5, 1'b1);
      run_case("c7_crlf", "a\r\n", 3, 64'h01_00_00, 1, c_CR_BAD, 1'b0, 3, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
